mem_port_arbiter: RTL and testbench

- Shares one memory port between the instruction-fetch path and the load/store path of the RV32I core.
- Accepts one request per requester, holds at most one transaction in flight on the memory port, and routes each response back to the requester that issued it.
- Drives the stall input of program_counter while a fetch or load/store has not completed.
- Load/store has priority; a starvation counter bounds how long fetch can be held off.

---
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, with one
// transaction in flight, LS priority, and a starvation bound for fetch.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_be,
    output logic                ls_gnt,
    output logic                ls_rvalid,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                stall,
    output logic                err_spurious
);

    // state     | meaning
    // IDLE      | no transaction, arbitrate requesters this cycle
    // WAIT_GNT  | mem_req asserted with latched payload, waiting for mem_gnt
    // WAIT_RESP | request accepted, waiting for mem_rvalid
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_GNT  = 2'd1;
    localparam logic [1:0] ST_WAIT_RESP = 2'd2;
    localparam logic       OWN_IF       = 1'b0;
    localparam logic       OWN_LS       = 1'b1;
    localparam logic [3:0] LIMIT        = 4'(STARVE_LIMIT);

    logic [1:0]          r_state;
    logic                r_owner;
    logic [3:0]          r_starve_cnt;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [DATA_W/8-1:0] r_mem_be;
    logic                r_err_spurious;

    logic w_idle;
    logic w_ls_win;
    logic w_gnt_ls;
    logic w_gnt_if;
    logic w_resp;

    // Fetch wins over a concurrent LS request only once it has lost LIMIT times in a row.
    assign w_idle   = (r_state == ST_IDLE) & ~reset;
    assign w_ls_win = ls_req & ~(if_req & (r_starve_cnt == LIMIT));
    assign w_gnt_ls = w_idle & w_ls_win;
    assign w_gnt_if = w_idle & if_req & ~w_ls_win;
    assign w_resp   = (r_state == ST_WAIT_RESP) & mem_rvalid;

    assign if_gnt       = w_gnt_if;
    assign ls_gnt       = w_gnt_ls;
    assign if_rvalid    = w_resp & (r_owner == OWN_IF);
    assign ls_rvalid    = w_resp & (r_owner == OWN_LS);
    assign if_rdata     = mem_rdata;
    assign ls_rdata     = mem_rdata;
    assign mem_req      = r_mem_req;
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign mem_be       = r_mem_be;
    assign err_spurious = r_err_spurious;

    assign stall = (if_req & ~if_rvalid) | (ls_req & ~ls_gnt)
                 | ((r_state != ST_IDLE) & (r_owner == OWN_LS) & ~ls_rvalid)
                 | reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_owner        <= OWN_IF;
            r_starve_cnt   <= 4'd0;
            r_mem_req      <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_mem_be       <= '0;
            r_err_spurious <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_ls) begin
                        r_state     <= ST_WAIT_GNT;
                        r_owner     <= OWN_LS;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= ls_we;
                        r_mem_addr  <= ls_addr;
                        r_mem_wdata <= ls_wdata;
                        r_mem_be    <= ls_be;
                        if (if_req && (r_starve_cnt != LIMIT))
                            r_starve_cnt <= r_starve_cnt + 4'd1;
                    end else if (w_gnt_if) begin
                        r_state      <= ST_WAIT_GNT;
                        r_owner      <= OWN_IF;
                        r_mem_req    <= 1'b1;
                        r_mem_we     <= 1'b0;
                        r_mem_addr   <= if_addr;
                        r_mem_wdata  <= '0;
                        r_mem_be     <= '1;
                        r_starve_cnt <= 4'd0;
                    end
                end
                ST_WAIT_GNT: begin
                    if (mem_gnt) begin
                        r_mem_req <= 1'b0;
                        r_state   <= ST_WAIT_RESP;
                    end
                end
                ST_WAIT_RESP: begin
                    if (mem_rvalid)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
            // A response with no accepted request outstanding is never forwarded.
            if (mem_rvalid && (r_state != ST_WAIT_RESP))
                r_err_spurious <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, store/fetch collision,
// starvation bound, memory backpressure and reset mid-transaction.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req, ls_we;
    logic [31:0] ls_addr, ls_wdata;
    logic [3:0]  ls_be;
    logic        ls_gnt, ls_rvalid;
    logic [31:0] ls_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        stall, err_spurious;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_be(ls_be), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .stall(stall), .err_spurious(err_spurious)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        if_req = 0; if_addr = '0;
        ls_req = 1; ls_we = 0; ls_addr = '0; ls_wdata = '0; ls_be = '0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
        #2;
        chk("rst_stall",   32'(stall),        32'd1);
        chk("rst_ls_gnt",  32'(ls_gnt),       32'd0);
        chk("rst_mem_req", 32'(mem_req),      32'd0);
        chk("rst_err",     32'(err_spurious), 32'd0);
        ls_req = 0;
        tick(); tick();
        reset = 1'b0;

        // single fetch
        tick();
        if_req = 1; if_addr = 32'h0000_0010;
        #2;
        chk("f_c0_if_gnt",  32'(if_gnt),  32'd1);
        chk("f_c0_mem_req", 32'(mem_req), 32'd0);
        chk("f_c0_stall",   32'(stall),   32'd1);
        tick();
        mem_gnt = 1;
        #2;
        chk("f_c1_mem_req",  32'(mem_req), 32'd1);
        chk("f_c1_mem_addr", mem_addr,     32'h0000_0010);
        chk("f_c1_mem_we",   32'(mem_we),  32'd0);
        chk("f_c1_mem_be",   32'(mem_be),  32'hF);
        chk("f_c1_if_gnt",   32'(if_gnt),  32'd0);
        chk("f_c1_stall",    32'(stall),   32'd1);
        tick();
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0050_0093;
        #2;
        chk("f_c2_mem_req",   32'(mem_req),   32'd0);
        chk("f_c2_if_rvalid", 32'(if_rvalid), 32'd1);
        chk("f_c2_if_rdata",  if_rdata,       32'h0050_0093);
        chk("f_c2_ls_rvalid", 32'(ls_rvalid), 32'd0);
        chk("f_c2_stall",     32'(stall),     32'd0);
        tick();
        mem_rvalid = 0; if_req = 0;
        #2;
        chk("f_c3_stall", 32'(stall),        32'd0);
        chk("f_c3_err",   32'(err_spurious), 32'd0);

        // store vs fetch collision
        tick();
        ls_req = 1; ls_we = 1; ls_addr = 32'h100; ls_wdata = 32'hDEADBEEF; ls_be = 4'hF;
        if_req = 1; if_addr = 32'h0000_0020;
        #2;
        chk("c_ls_gnt",    32'(ls_gnt), 32'd1);
        chk("c_if_gnt",    32'(if_gnt), 32'd0);
        chk("c_stall0",    32'(stall),  32'd1);
        tick();
        ls_req = 0; mem_gnt = 1;
        #2;
        chk("c_mem_we",    32'(mem_we), 32'd1);
        chk("c_mem_addr",  mem_addr,    32'h100);
        chk("c_mem_wdata", mem_wdata,   32'hDEADBEEF);
        chk("c_mem_be",    32'(mem_be), 32'hF);
        chk("c_stall1",    32'(stall),  32'd1);
        tick();
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0;
        #2;
        chk("c_ls_rvalid", 32'(ls_rvalid), 32'd1);
        chk("c_if_rvalid", 32'(if_rvalid), 32'd0);
        chk("c_stall2",    32'(stall),     32'd1);
        tick();
        mem_rvalid = 0;
        #2;
        chk("c_if_gnt_after", 32'(if_gnt), 32'd1);
        tick();
        mem_gnt = 1;
        #2;
        chk("c_f_mem_addr", mem_addr, 32'h0000_0020);
        tick();
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h1234_5678;
        #2;
        chk("c_f_if_rdata", if_rdata, 32'h1234_5678);

        // starvation: LS re-requests every IDLE cycle while fetch waits
        if_addr = 32'h0000_0040;
        for (int i = 0; i < 4; i++) begin
            tick();
            mem_rvalid = 0;
            ls_req = 1; ls_we = 0; ls_addr = 32'h300 + 32'(i) * 4;
            #2;
            chk("s_ls_gnt", 32'(ls_gnt), 32'd1);
            chk("s_if_gnt", 32'(if_gnt), 32'd0);
            tick();
            ls_req = 0; mem_gnt = 1;
            #2;
            chk("s_mem_addr", mem_addr, 32'h300 + 32'(i) * 4);
            tick();
            mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'(i) + 32'hA0;
            #2;
            chk("s_ls_rdata", ls_rdata, 32'(i) + 32'hA0);
        end
        tick();
        mem_rvalid = 0;
        ls_req = 1; ls_we = 0; ls_addr = 32'h400;
        #2;
        chk("s5_if_gnt", 32'(if_gnt), 32'd1);
        chk("s5_ls_gnt", 32'(ls_gnt), 32'd0);
        chk("s5_stall",  32'(stall),  32'd1);
        tick();
        mem_gnt = 1;
        #2;
        chk("s5_starve_cnt", 32'(dut.r_starve_cnt), 32'd0);
        chk("s5_mem_addr",   mem_addr,              32'h0000_0040);
        tick();
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hCAFE_0001;
        #2;
        chk("s5_if_rvalid", 32'(if_rvalid), 32'd1);
        chk("s5_ls_rvalid", 32'(ls_rvalid), 32'd0);

        // memory backpressure on the pending LS load
        tick();
        mem_rvalid = 0; if_req = 0;
        #2;
        chk("b_ls_gnt", 32'(ls_gnt), 32'd1);
        tick();
        ls_req = 0; if_req = 1; if_addr = 32'h0000_0080;
        for (int i = 0; i < 5; i++) begin
            #2;
            chk("b_mem_req",  32'(mem_req), 32'd1);
            chk("b_mem_addr", mem_addr,      32'h400);
            chk("b_gnts",     32'({if_gnt, ls_gnt}), 32'd0);
            tick();
        end
        mem_gnt = 1;
        #2;
        chk("b_mem_req_last", 32'(mem_req), 32'd1);
        tick();
        mem_gnt = 0; if_req = 0;
        #2;
        chk("r_pre_stall",   32'(stall),   32'd1);
        chk("r_pre_mem_req", 32'(mem_req), 32'd0);

        // reset while in WAIT_RESP
        reset = 1;
        #1;
        chk("r_mem_addr", mem_addr,      32'd0);
        chk("r_mem_be",   32'(mem_be),   32'd0);
        chk("r_stall",    32'(stall),    32'd1);
        chk("r_rvalids",  32'({if_rvalid, ls_rvalid}), 32'd0);
        tick();
        reset = 0;
        #2;
        chk("r_post_stall", 32'(stall), 32'd0);
        tick();
        mem_rvalid = 1; mem_rdata = 32'hBAD0_BAD0;
        #2;
        chk("r_late_rvalids", 32'({if_rvalid, ls_rvalid}), 32'd0);
        chk("r_late_err0",    32'(err_spurious),           32'd0);
        tick();
        mem_rvalid = 0;
        #2;
        chk("r_err_set", 32'(err_spurious), 32'd1);
        tick(); tick();
        chk("r_err_sticky", 32'(err_spurious), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
